data_mem_request: RTL and testbench
===================================

Name: data_mem_request

Overview:
- Sequential load/store unit between the CPU datapath and the data-memory bus.
- Takes the ALU result as the effective address and the rs2 value as store data.
- Drives a request/ack bus with byte lane selects and stalls the core until the access completes.
- Returns aligned, sign/zero-extended load data; flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 16, maximum cycles in ACCESS waiting for bus_ack before aborting with an error.
- CNT_W, 5, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- nRst  input  1  asynchronous active-low reset.
- mem_read  input  1  current instruction is a load.
- mem_write  input  1  current instruction is a store.
- addr  input  32  effective byte address (ALU result).
- wdata  input  32  store data (rs2).
- funct3  input  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- bus_addr  output  32  word-aligned address {addr[31:2],2'b00}.
- bus_wdata  output  32  lane-replicated store data.
- bus_sel  output  4  byte-lane enables.
- bus_ren  output  1  read request.
- bus_wen  output  1  write request.
- bus_rdata  input  32  read data, valid with bus_ack.
- bus_ack  input  1  access complete.
- rdata  output  32  extended load result.
- stall  output  1  hold PC/register file.
- done  output  1  one-cycle completion pulse.
- misaligned  output  1  one-cycle misaligned-access flag.
- bus_err  output  1  one-cycle timeout flag.

Behaviour:
- Reset (asynchronous, effective immediately, including mid-access):
  - State returns to IDLE; counter clears.
  - All outputs go to 0; rdata = 0.
- States and transitions:
  - IDLE: a request is mem_read | mem_write.
    - If the request is misaligned, go to DONE with misaligned set. No bus request is issued.
    - If the request is aligned, latch addr/wdata/funct3/direction and go to ACCESS.
  - ACCESS:
    - bus_ren or bus_wen is held steady from the latched registers.
    - On bus_ack, go to DONE. For a read, rdata captures the extended bus_rdata.
    - If the counter reaches TIMEOUT without ack, go to DONE with bus_err set and rdata = 0.
  - DONE: for exactly one cycle, done = 1, stall = 0, and misaligned/bus_err are valid. Then go to IDLE.
- Stall:
  - Combinational.
  - stall = 1 in IDLE while a request is present.
  - stall = 1 throughout ACCESS.
  - stall = 0 in DONE, so the core commits that cycle.
- Latency:
  - Ack in the first ACCESS cycle gives 3 cycles from request to done.
  - Each extra wait cycle adds 1.
- Simultaneous mem_read and mem_write: treated as a write; the read is ignored.
- Alignment:
  - Halfword accesses require addr[0] = 0.
  - Word accesses require addr[1:0] = 00.
  - Byte accesses are always aligned.
  - Unsupported funct3 values (011, 110, 111) are flagged as misaligned.
- Store lanes:
  - SB: bus_sel = 0001 << addr[1:0]; bus_wdata = {4{wdata[7:0]}}.
  - SH: bus_sel = 0011 << {addr[1],1'b0}; bus_wdata = {2{wdata[15:0]}}.
  - SW: bus_sel = 1111; bus_wdata = wdata.
- Load extraction:
  - Byte lane is selected by addr[1:0]; halfword by addr[1].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
  - Loads drive bus_sel the same way as stores.
- Bus signals are zero outside ACCESS.
- bus_ack outside ACCESS is ignored.
- Counter: cleared on entry to ACCESS, increments each ACCESS cycle; TIMEOUT is counted from 0.
- Inputs changing during ACCESS do not affect the bus outputs.

Decomposition:
- cpu_pkg additions:
  - typedef enum mem_state_t {IDLE, ACCESS, DONE}.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
- Sub-module load_extender: combinational. Inputs bus_rdata, addr[1:0], funct3. Output is the 32-bit extended value. Instantiated once, and reusable by a future instruction-side or cache unit.

Test Plan:
- Reset mid-ACCESS: assert nRst = 0 while bus_ren = 1 -> all outputs 0 in the same cycle; IDLE after release.
- LW at addr 0x0000_1004, ack on the first ACCESS cycle, bus_rdata = 0xDEAD_BEEF:
  - Bus side: bus_addr = 0x0000_1004, bus_sel = 1111.
  - Result: done on cycle 3 with rdata = 0xDEAD_BEEF; stall high cycles 1-2, low cycle 3.
- LB at addr 0x0000_2003, bus_rdata = 0x8000_0000 -> bus_sel = 1000, rdata = 0xFFFF_FF80.
- LBU at the same address and data -> rdata = 0x0000_0080.
- SH at addr 0x0000_3002 with wdata = 0x1234_ABCD, ack after 2 wait cycles:
  - bus_wen = 1, bus_sel = 1100, bus_wdata = 0xABCD_ABCD.
  - done on cycle 5.
- SW at addr 0x0000_4001 -> misaligned = 1 and done = 1 in cycle 2, no bus_wen ever asserted; LH at 0x0000_4001 -> same response.
- LW with bus_ack held low -> bus_err = 1 and done = 1 after TIMEOUT = 16 ACCESS cycles, rdata = 0; mem_read = mem_write = 1 -> write performed.

Source files
------------

// File: rtl/data_mem_request_pkg.sv
// Shared types and helpers for the data-side load/store path.
// Lane-select and replication helpers are shared by loads and stores alike.
package data_mem_request_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsupported size encodings report as misaligned so they never reach the bus.
    function automatic logic isAligned(input logic [2:0] f3, input logic [1:0] addrLo);
        logic ok;
        case (f3)
            F3_B, F3_BU: ok = 1'b1;
            F3_H, F3_HU: ok = ~addrLo[0];
            F3_W:        ok = (addrLo == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] laneSel(input logic [2:0] f3, input logic [1:0] addrLo);
        logic [3:0] sel;
        case (f3[1:0])
            2'b00:   sel = 4'b0001 << addrLo;
            2'b01:   sel = 4'b0011 << {addrLo[1], 1'b0};
            default: sel = 4'b1111;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] laneData(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/data_mem_request_load_extender.sv
// Picks the addressed byte/halfword out of a bus word and sign- or zero-extends it.
// Purely combinational so an instruction-side or cache unit can reuse it as-is.
module load_extender
    import data_mem_request_pkg::*;
(
    input  logic [31:0] busRdata,
    input  logic [1:0]  addrLo,
    input  logic [2:0]  funct3,
    output logic [31:0] loadData
);

    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    always_comb begin
        byteVal = busRdata[7:0];
        case (addrLo)
            2'd0: byteVal = busRdata[7:0];
            2'd1: byteVal = busRdata[15:8];
            2'd2: byteVal = busRdata[23:16];
            2'd3: byteVal = busRdata[31:24];
            default: byteVal = busRdata[7:0];
        endcase
    end

    assign halfVal = addrLo[1] ? busRdata[31:16] : busRdata[15:0];

    always_comb begin
        loadData = '0;
        case (funct3)
            F3_B:    loadData = {{24{byteVal[7]}}, byteVal};
            F3_BU:   loadData = {24'd0, byteVal};
            F3_H:    loadData = {{16{halfVal[15]}}, halfVal};
            F3_HU:   loadData = {16'd0, halfVal};
            F3_W:    loadData = busRdata;
            default: loadData = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_request.sv
// Sequential load/store unit: turns a CPU load/store into one request/ack bus access
// and stalls the core until the access completes, faults, or times out.
//
// state  | meaning
// IDLE   | waiting for mem_read/mem_write; misaligned requests go straight to DONE
// ACCESS | bus request held from latched operands until ack or timeout
// DONE   | one-cycle completion: done=1, stall=0, misaligned/bus_err valid
module data_mem_request
    import data_mem_request_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    output logic        bus_ren,
    output logic        bus_wen,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        misaligned,
    output logic        bus_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t        state, nextState;
    logic [31:0]       addrQ, wdataQ, rdataQ, loadExt;
    logic [2:0]        f3Q;
    logic              writeQ, misQ, errQ;
    logic [CNT_W-1:0]  cnt;
    logic              request, reqAligned, timeoutHit;

    assign request    = mem_read | mem_write;
    assign reqAligned = isAligned(funct3, addr[1:0]);
    assign timeoutHit = (cnt == CNT_LAST);

    load_extender uLoadExt (
        .busRdata (bus_rdata),
        .addrLo   (addrQ[1:0]),
        .funct3   (f3Q),
        .loadData (loadExt)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (request) nextState = reqAligned ? ACCESS : DONE;
            ACCESS:  if (bus_ack || timeoutHit) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Operand latch, timeout counter and completion status.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            addrQ  <= '0;
            wdataQ <= '0;
            f3Q    <= '0;
            writeQ <= 1'b0;
            cnt    <= '0;
            rdataQ <= '0;
            misQ   <= 1'b0;
            errQ   <= 1'b0;
        end else begin
            cnt <= (state == ACCESS) ? cnt + CNT_W'(1) : '0;
            case (state)
                IDLE: begin
                    if (request && reqAligned) begin
                        addrQ  <= addr;
                        wdataQ <= wdata;
                        f3Q    <= funct3;
                        writeQ <= mem_write;
                    end else if (request) begin
                        misQ   <= 1'b1;
                        errQ   <= 1'b0;
                        rdataQ <= '0;
                    end
                end
                ACCESS: begin
                    if (bus_ack) begin
                        rdataQ <= writeQ ? '0 : loadExt;
                        misQ   <= 1'b0;
                        errQ   <= 1'b0;
                    end else if (timeoutHit) begin
                        rdataQ <= '0;
                        misQ   <= 1'b0;
                        errQ   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // stall is gated by reset so the core sees a quiet interface while nRst is low.
    always_comb begin
        bus_addr   = '0;
        bus_wdata  = '0;
        bus_sel    = '0;
        bus_ren    = 1'b0;
        bus_wen    = 1'b0;
        stall      = 1'b0;
        done       = 1'b0;
        misaligned = 1'b0;
        bus_err    = 1'b0;
        case (state)
            IDLE: stall = nRst & request;
            ACCESS: begin
                stall     = nRst;
                bus_addr  = {addrQ[31:2], 2'b00};
                bus_sel   = laneSel(f3Q, addrQ[1:0]);
                bus_ren   = ~writeQ;
                bus_wen   = writeQ;
                bus_wdata = writeQ ? laneData(f3Q, wdataQ) : '0;
            end
            DONE: begin
                done       = 1'b1;
                misaligned = misQ;
                bus_err    = errQ;
            end
            default: ;
        endcase
    end

    assign rdata = rdataQ;

endmodule

// File: tb/tb_data_mem_request.sv
// Bench for data_mem_request: directed vector table, reset-mid-access sequence,
// and randomized transactions checked against an arithmetic reference model.
module tb_data_mem_request;

    logic        clk = 1'b0;
    logic        nRst;
    logic        mem_read, mem_write;
    logic [31:0] addr, wdata;
    logic [2:0]  funct3;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_sel;
    logic        bus_ren, bus_wen;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [31:0] rdata;
    logic        stall, done, misaligned, bus_err;

    int nVec  = 0;
    int nChk  = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    data_mem_request #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .nRst(nRst),
        .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .funct3(funct3),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
        .bus_ren(bus_ren), .bus_wen(bus_wen),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .rdata(rdata), .stall(stall), .done(done),
        .misaligned(misaligned), .bus_err(bus_err)
    );

    typedef struct {
        bit          rd, wr;
        logic [31:0] addr, wdata;
        logic [2:0]  f3;
        int          waits;
        logic [31:0] brdata;
        int          expDone;
        logic [31:0] expRdata;
        bit          expMis, expErr, expBus;
        logic [3:0]  expSel;
        logic [31:0] expWdata;
    } vec_t;

    typedef struct {
        int          doneCycle;
        logic [31:0] rdata, bAddr, bWdata;
        logic [3:0]  bSel;
        bit          mis, err, sawRen, sawWen, stallBad, flagBad, unstable, postBad;
    } obs_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkVec(input bit rd, input bit wr, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [2:0] f3, input int waits,
                                   input logic [31:0] br, input int eDone, input logic [31:0] eRd,
                                   input bit eMis, input bit eErr, input bit eBus,
                                   input logic [3:0] eSel, input logic [31:0] eWd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.f3 = f3; v.waits = waits;
        v.brdata = br; v.expDone = eDone; v.expRdata = eRd; v.expMis = eMis;
        v.expErr = eErr; v.expBus = eBus; v.expSel = eSel; v.expWdata = eWd;
        return v;
    endfunction

    // Reference model: access size in bytes, alignment by modulo, lanes by index arithmetic.
    function automatic vec_t model(input vec_t vin);
        vec_t v = vin;
        int bytes, off;
        logic [31:0] val, lim;
        off = int'(v.addr % 4);
        case (v.f3)
            3'd0, 3'd4: bytes = 1;
            3'd1, 3'd5: bytes = 2;
            3'd2:       bytes = 4;
            default:    bytes = 0;
        endcase
        v.expRdata = '0; v.expMis = 0; v.expErr = 0; v.expBus = 0; v.expSel = '0; v.expWdata = '0;
        if (bytes == 0 || (off % bytes) != 0) begin
            v.expDone = 2;
            v.expMis  = 1;
            return v;
        end
        v.expBus = 1;
        v.expSel = 4'(((1 << bytes) - 1) << off);
        for (int i = 0; i < 4; i++) v.expWdata[8*i +: 8] = v.wdata[8*(i % bytes) +: 8];
        if (v.waits >= 16) begin
            v.expDone = 2 + 16;
            v.expErr  = 1;
        end else begin
            v.expDone = 3 + v.waits;
            if (!v.wr) begin
                if (bytes == 4) v.expRdata = v.brdata;
                else begin
                    lim = 32'(1) << (8 * bytes);
                    val = (v.brdata >> (8 * off)) % lim;
                    if (v.f3[2] == 1'b0 && val >= lim / 2) val = val - lim;
                    v.expRdata = val;
                end
            end
        end
        return v;
    endfunction

    task automatic runTxn(input vec_t v, input bit scramble, output obs_t o);
        int accIdx = 0;
        bit seenBus = 0;
        o = '{default: 0};
        @(posedge clk); #1;
        mem_read = v.rd; mem_write = v.wr; addr = v.addr; wdata = v.wdata; funct3 = v.f3;
        bus_rdata = scramble ? $urandom : v.brdata;
        bus_ack = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (done == stall) o.stallBad = 1;
            if ((misaligned || bus_err) && !done) o.flagBad = 1;
            if (bus_ren || bus_wen) begin
                o.sawRen |= bus_ren;
                o.sawWen |= bus_wen;
                if (!seenBus) begin
                    o.bAddr = bus_addr; o.bSel = bus_sel; o.bWdata = bus_wdata;
                    seenBus = 1;
                end else if (bus_addr !== o.bAddr || bus_sel !== o.bSel || bus_wdata !== o.bWdata)
                    o.unstable = 1;
                bus_ack = (accIdx == v.waits);
                bus_rdata = (bus_ack || !scramble) ? v.brdata : $urandom;
                accIdx++;
                if (scramble) begin
                    addr = $urandom; wdata = $urandom; funct3 = 3'($urandom_range(0, 7));
                end
            end else begin
                bus_ack = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (done) begin
                o.doneCycle = cyc;
                o.rdata = rdata; o.mis = misaligned; o.err = bus_err;
                mem_read = 0; mem_write = 0;
                break;
            end
        end
        if (o.doneCycle == 0) begin
            mem_read = 0; mem_write = 0;
        end
        @(negedge clk);
        bus_ack = 1'b0;
        if (done || stall || bus_ren || bus_wen || misaligned || bus_err) o.postBad = 1;
    endtask

    task automatic checkVec(input string tag, input vec_t v, input obs_t o);
        nVec++;
        check({tag, " done_cycle"}, 32'(o.doneCycle), 32'(v.expDone));
        check({tag, " rdata"}, o.rdata, v.expRdata);
        check({tag, " misaligned"}, 32'(o.mis), 32'(v.expMis));
        check({tag, " bus_err"}, 32'(o.err), 32'(v.expErr));
        check({tag, " stall_pattern_bad"}, 32'(o.stallBad), 32'd0);
        check({tag, " flag_outside_done"}, 32'(o.flagBad), 32'd0);
        check({tag, " post_done_not_idle"}, 32'(o.postBad), 32'd0);
        check({tag, " saw_ren"}, 32'(o.sawRen), 32'(v.expBus && !v.wr));
        check({tag, " saw_wen"}, 32'(o.sawWen), 32'(v.expBus && v.wr));
        if (v.expBus) begin
            check({tag, " bus_addr"}, o.bAddr, {v.addr[31:2], 2'b00});
            check({tag, " bus_sel"}, 32'(o.bSel), 32'(v.expSel));
            check({tag, " bus_unstable"}, 32'(o.unstable), 32'd0);
            if (v.wr) check({tag, " bus_wdata"}, o.bWdata, v.expWdata);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " bus_ren"}, 32'(bus_ren), 32'd0);
        check({tag, " bus_wen"}, 32'(bus_wen), 32'd0);
        check({tag, " bus_sel"}, 32'(bus_sel), 32'd0);
        check({tag, " bus_addr"}, bus_addr, 32'd0);
        check({tag, " bus_wdata"}, bus_wdata, 32'd0);
        check({tag, " rdata"}, rdata, 32'd0);
        check({tag, " stall"}, 32'(stall), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " misaligned"}, 32'(misaligned), 32'd0);
        check({tag, " bus_err"}, 32'(bus_err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        vec_t v;
        obs_t o;

        vecs.push_back(mkVec(1,0,32'h0000_1004,32'h0,3'b010, 0,32'hDEAD_BEEF, 3,32'hDEAD_BEEF,0,0,1,4'hF,32'h0));
        vecs.push_back(mkVec(1,0,32'h0000_2003,32'h0,3'b000, 0,32'h8000_0000, 3,32'hFFFF_FF80,0,0,1,4'h8,32'h0));
        vecs.push_back(mkVec(1,0,32'h0000_2003,32'h0,3'b100, 0,32'h8000_0000, 3,32'h0000_0080,0,0,1,4'h8,32'h0));
        vecs.push_back(mkVec(0,1,32'h0000_3002,32'h1234_ABCD,3'b001, 2,32'h0, 5,32'h0,0,0,1,4'hC,32'hABCD_ABCD));
        vecs.push_back(mkVec(0,1,32'h0000_4001,32'h55,3'b010, 0,32'h0, 2,32'h0,1,0,0,4'h0,32'h0));
        vecs.push_back(mkVec(1,0,32'h0000_4001,32'h0,3'b001, 0,32'h0, 2,32'h0,1,0,0,4'h0,32'h0));
        vecs.push_back(mkVec(1,0,32'h0000_4000,32'h0,3'b010, 100,32'hCAFE_F00D, 18,32'h0,0,1,1,4'hF,32'h0));
        vecs.push_back(mkVec(1,1,32'h0000_5000,32'h1122_3344,3'b010, 1,32'hFFFF_FFFF, 4,32'h0,0,0,1,4'hF,32'h1122_3344));
        vecs.push_back(mkVec(1,0,32'h0000_6000,32'h0,3'b011, 0,32'h0, 2,32'h0,1,0,0,4'h0,32'h0));
        vecs.push_back(mkVec(1,0,32'h0000_7002,32'h0,3'b101, 0,32'hF00D_1234, 3,32'h0000_F00D,0,0,1,4'hC,32'h0));
        vecs.push_back(mkVec(1,0,32'h0000_7002,32'h0,3'b001, 0,32'hF00D_1234, 3,32'hFFFF_F00D,0,0,1,4'hC,32'h0));
        vecs.push_back(mkVec(0,1,32'h0000_8001,32'h0000_00AB,3'b000, 0,32'h0, 3,32'h0,0,0,1,4'h2,32'hABAB_ABAB));
        vecs.push_back(mkVec(1,0,32'h0000_9008,32'h0,3'b010, 15,32'h0BAD_F00D, 18,32'h0BAD_F00D,0,0,1,4'hF,32'h0));
        vecs.push_back(mkVec(1,0,32'h0000_2001,32'h0,3'b000, 0,32'h0000_7F00, 3,32'h0000_007F,0,0,1,4'h2,32'h0));
        vecs.push_back(mkVec(0,1,32'h0000_A000,32'h0,3'b110, 0,32'h0, 2,32'h0,1,0,0,4'h0,32'h0));

        nRst = 0; mem_read = 0; mem_write = 0; addr = '0; wdata = '0; funct3 = '0;
        bus_rdata = '0; bus_ack = 0;
        #3;
        checkAllZero("reset_initial");
        @(negedge clk); @(negedge clk);
        nRst = 1;

        foreach (vecs[i]) begin
            runTxn(vecs[i], 1'b0, o);
            checkVec($sformatf("vec%0d", i), vecs[i], o);
        end

        // Reset asserted mid-ACCESS with the load request still present.
        @(posedge clk); #1;
        mem_read = 1; mem_write = 0; addr = 32'h0000_9000; funct3 = 3'b010; bus_ack = 0;
        @(negedge clk);
        @(negedge clk);
        check("midreset bus_ren_before", 32'(bus_ren), 32'd1);
        #1 nRst = 0;
        #1 checkAllZero("midreset");
        @(negedge clk);
        mem_read = 0;
        nRst = 1;
        @(negedge clk);
        check("midreset idle_stall", 32'(stall), 32'd0);
        check("midreset idle_ren", 32'(bus_ren), 32'd0);
        check("midreset idle_done", 32'(done), 32'd0);

        for (int n = 0; n < 80; n++) begin
            int pick;
            v = '{default: 0};
            pick = $urandom_range(0, 2);
            v.rd = (pick != 1);
            v.wr = (pick != 0);
            v.addr = $urandom;
            v.wdata = $urandom;
            v.brdata = $urandom;
            pick = $urandom_range(0, 9);
            v.f3 = (pick < 8) ? 3'(pick % 6 == 3 ? 4 : pick % 6) : 3'($urandom_range(0, 7));
            pick = $urandom_range(0, 9);
            if (pick < 7)       v.waits = $urandom_range(0, 3);
            else if (pick == 7) v.waits = 15;
            else if (pick == 8) v.waits = 16;
            else                v.waits = $urandom_range(4, 14);
            v = model(v);
            runTxn(v, 1'b1, o);
            checkVec($sformatf("rnd%0d", n), v, o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
